// File: rtl/cpu_consts.sv
// ----------------------------------------------------------------------------
// cpu_consts
//   Shared constants and encodings for the RV64 core.
//   - XLEN        : architectural register width (64)
//   - rf_wr_src_t : register-file write-data source select
//   - mem_size_t  : load/store access size
//   - size_bytes  : helper returning the byte count for an access size
// ----------------------------------------------------------------------------
package cpu_consts;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        RF_SRC_ALU = 2'd0,
        RF_SRC_MEM = 2'd1,
        RF_SRC_IMM = 2'd2,
        RF_SRC_PC  = 2'd3
    } rf_wr_src_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    function automatic logic [3:0] size_bytes(input mem_size_t sz);
        case (sz)
            SZ_B:    size_bytes = 4'd1;
            SZ_H:    size_bytes = 4'd2;
            SZ_W:    size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align
//   Extracts a byte/half/word/double from a 64-bit memory row and extends it
//   to XLEN bits.
//   Ports:
//     row_i   in  64  full data-memory row
//     idx_i   in  3   byte offset of the access within the row
//     size_i  in  2   access size (mem_size_t)
//     zext_i  in  1   1 = zero-extend, 0 = sign-extend (ignored for D)
//     load_o  out 64  extended load value
// ----------------------------------------------------------------------------
module load_align
    import cpu_consts::*;
(
    input  logic [XLEN-1:0] row_i,
    input  logic [2:0]      idx_i,
    input  logic [1:0]      size_i,
    input  logic            zext_i,
    output logic [XLEN-1:0] load_o
);

    mem_size_t       size;
    logic [2:0]      aligned_idx;
    logic [XLEN-1:0] shifted;

    assign size = mem_size_t'(size_i);

    // Misaligned offsets are not trapped here; the low offset bits are
    // simply dropped so the access lands on its natural boundary.
    always_comb begin
        aligned_idx = 3'd0;
        case (size)
            SZ_B:    aligned_idx = idx_i;
            SZ_H:    aligned_idx = {idx_i[2:1], 1'b0};
            SZ_W:    aligned_idx = {idx_i[2], 2'b00};
            default: aligned_idx = 3'd0;
        endcase
    end

    // Shift the wanted field down to bit 0 (byte offset times 8).
    assign shifted = row_i >> {aligned_idx, 3'b000};

    // Keep the low field and either zero-fill or replicate its top bit.
    always_comb begin
        load_o = shifted;
        case (size)
            SZ_B:    load_o = zext_i ? {56'd0, shifted[7:0]}
                                     : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_o = zext_i ? {48'd0, shifted[15:0]}
                                     : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    load_o = zext_i ? {32'd0, shifted[31:0]}
                                     : {{32{shifted[31]}}, shifted[31:0]};
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage
//   RV64 writeback stage: selects the register-file write data from the ALU
//   result, the extracted load, the immediate, or the link address (PC+4).
//   Ports:
//     clk                 in  1   stage clock
//     reset_i             in  1   synchronous active-high reset
//     alu_res_i           in  64  ALU result
//     data_mem_rd_i       in  64  data-memory row read
//     instr_imm_i         in  64  sign-extended immediate
//     pc_val_i            in  64  instruction PC
//     rf_wr_data_src_i    in  2   write-data select (rf_wr_src_t)
//     data_byte_en_i      in  2   load size (mem_size_t)
//     data_zero_extnd_i   in  1   1 = zero-extend load
//     data_mem_row_idx_i  in  3   byte offset within the row
//     rf_wr_data_o        out 64  register-file write data
//   Configuration macro WRITEBACK_OUT_REG_EN:
//     defined   -> output registered on posedge clk, reset_i forces 0
//     undefined -> purely combinational, clk/reset_i unused
// ----------------------------------------------------------------------------
module writeback_stage
    import cpu_consts::*;
(
    input  logic            clk,
    input  logic            reset_i,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic [XLEN-1:0] data_mem_rd_i,
    input  logic [XLEN-1:0] instr_imm_i,
    input  logic [XLEN-1:0] pc_val_i,
    input  logic [1:0]      rf_wr_data_src_i,
    input  logic [1:0]      data_byte_en_i,
    input  logic            data_zero_extnd_i,
    input  logic [2:0]      data_mem_row_idx_i,
    output logic [XLEN-1:0] rf_wr_data_o
);

    rf_wr_src_t      src_sel;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] link_addr;
    logic [XLEN-1:0] wr_data_next;

    assign src_sel = rf_wr_src_t'(rf_wr_data_src_i);

    load_align u_load_align (
        .row_i  (data_mem_rd_i),
        .idx_i  (data_mem_row_idx_i),
        .size_i (data_byte_en_i),
        .zext_i (data_zero_extnd_i),
        .load_o (load_data)
    );

    // Link address wraps modulo 2^64 like any other RV64 add.
    assign link_addr = pc_val_i + 64'd4;

    always_comb begin
        wr_data_next = alu_res_i;
        case (src_sel)
            RF_SRC_ALU: wr_data_next = alu_res_i;
            RF_SRC_MEM: wr_data_next = load_data;
            RF_SRC_IMM: wr_data_next = instr_imm_i;
            RF_SRC_PC:  wr_data_next = link_addr;
            default:    wr_data_next = alu_res_i;
        endcase
    end

`ifdef WRITEBACK_OUT_REG_EN
    // Reset takes priority over new data at the same edge.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            rf_wr_data_o <= '0;
        end else begin
            rf_wr_data_o <= wr_data_next;
        end
    end
`else
    // Clock and reset are only meaningful in the registered build.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset_i;
    assign rf_wr_data_o     = wr_data_next;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ----------------------------------------------------------------------------
// tb_writeback_stage
//   Self-checking bench for writeback_stage: directed vectors plus random
//   transactions checked against a byte-level behavioural model.
// ----------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [63:0] alu_res_i;
    logic [63:0] data_mem_rd_i;
    logic [63:0] instr_imm_i;
    logic [63:0] pc_val_i;
    logic [1:0]  rf_wr_data_src_i;
    logic [1:0]  data_byte_en_i;
    logic        data_zero_extnd_i;
    logic [2:0]  data_mem_row_idx_i;
    logic [63:0] rf_wr_data_o;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk                (clk),
        .reset_i            (reset_i),
        .alu_res_i          (alu_res_i),
        .data_mem_rd_i      (data_mem_rd_i),
        .instr_imm_i        (instr_imm_i),
        .pc_val_i           (pc_val_i),
        .rf_wr_data_src_i   (rf_wr_data_src_i),
        .data_byte_en_i     (data_byte_en_i),
        .data_zero_extnd_i  (data_zero_extnd_i),
        .data_mem_row_idx_i (data_mem_row_idx_i),
        .rf_wr_data_o       (rf_wr_data_o)
    );

    task automatic check_output(input string tag, input logic [63:0] got,
                                input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Byte-level reference: gather the naturally aligned bytes and extend.
    function automatic logic [63:0] model_load(input logic [63:0] row,
                                               input int idx, input int size,
                                               input bit zext);
        int          nbytes;
        int          base;
        logic [63:0] val;
        nbytes = 1 << size;
        base   = idx - (idx % nbytes);
        val    = 64'd0;
        for (int i = 0; i < nbytes; i++)
            val[8*i +: 8] = row[8*(base+i) +: 8];
        if (nbytes < 8 && !zext && val[8*nbytes-1])
            for (int b = 8*nbytes; b < 64; b++)
                val[b] = 1'b1;
        return val;
    endfunction

    function automatic logic [63:0] model_out(input int src, input logic [63:0] alu,
                                              input logic [63:0] row,
                                              input logic [63:0] imm,
                                              input logic [63:0] pc,
                                              input int size, input bit zext,
                                              input int idx);
        case (src)
            0:       return alu;
            1:       return model_load(row, idx, size, zext);
            2:       return imm;
            default: return pc + 64'd4;
        endcase
    endfunction

    // Drives one transaction and waits until its result is visible.
    task automatic apply_stimulus(input int src, input logic [63:0] alu,
                                  input logic [63:0] row, input logic [63:0] imm,
                                  input logic [63:0] pc, input int size,
                                  input bit zext, input int idx);
        alu_res_i          = alu;
        data_mem_rd_i      = row;
        instr_imm_i        = imm;
        pc_val_i           = pc;
        rf_wr_data_src_i   = 2'(src);
        data_byte_en_i     = 2'(size);
        data_zero_extnd_i  = zext;
        data_mem_row_idx_i = 3'(idx);
`ifdef WRITEBACK_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #2;
`endif
    endtask

    task automatic run_vec(input string tag, input int src, input logic [63:0] alu,
                           input logic [63:0] row, input logic [63:0] imm,
                           input logic [63:0] pc, input int size, input bit zext,
                           input int idx, input logic [63:0] exp);
        apply_stimulus(src, alu, row, imm, pc, size, zext, idx);
        check_output(tag, rf_wr_data_o, exp);
    endtask

    initial begin
        logic [63:0] r_alu, r_row, r_imm, r_pc, exp;
        int          r_src, r_size, r_idx;
        bit          r_zext;

        reset_i = 1'b1;
        @(negedge clk);
`ifdef WRITEBACK_OUT_REG_EN
        // Inputs are non-zero; reset must still win at the edge.
        apply_stimulus(0, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 0);
        check_output("reset_clears", rf_wr_data_o, 64'h0);
        reset_i = 1'b0;
        apply_stimulus(0, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 0);
        check_output("first_after_reset", rf_wr_data_o, 64'hDEAD_BEEF_0000_0001);
`else
        // Combinational build: reset has no effect on the output.
        apply_stimulus(0, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 0);
        check_output("reset_ignored", rf_wr_data_o, 64'hDEAD_BEEF_0000_0001);
        reset_i = 1'b0;
`endif

        run_vec("alu", 0, 64'h1234_5678_9ABC_DEF0, 64'h1, 64'h2, 64'h3, 0, 0, 0,
                64'h1234_5678_9ABC_DEF0);
        run_vec("lb_sext", 1, 64'h5, 64'h0000_0000_8000_0000, 0, 0, 0, 0, 3,
                64'hFFFF_FFFF_FFFF_FF80);
        run_vec("lbu_zext", 1, 64'h5, 64'h0000_0000_8000_0000, 0, 0, 0, 1, 3,
                64'h80);
        run_vec("lh_idx6", 1, 0, 64'hBEEF_0000_0000_0000, 0, 0, 1, 0, 6,
                64'hFFFF_FFFF_FFFF_BEEF);
        run_vec("lh_idx7_misal", 1, 0, 64'hBEEF_0000_0000_0000, 0, 0, 1, 0, 7,
                64'hFFFF_FFFF_FFFF_BEEF);
        run_vec("lhu_idx6", 1, 0, 64'hBEEF_0000_0000_0000, 0, 0, 1, 1, 6,
                64'hBEEF);
        run_vec("lw_idx4", 1, 0, 64'h7654_3210_DEAD_BEEF, 0, 0, 2, 0, 4,
                64'h7654_3210);
        run_vec("lw_idx0_sext", 1, 0, 64'h7654_3210_DEAD_BEEF, 0, 0, 2, 0, 0,
                64'hFFFF_FFFF_DEAD_BEEF);
        run_vec("lwu_idx1_misal", 1, 0, 64'h7654_3210_DEAD_BEEF, 0, 0, 2, 1, 1,
                64'hDEAD_BEEF);
        run_vec("ld_idx5", 1, 0, 64'h7654_3210_DEAD_BEEF, 0, 0, 3, 0, 5,
                64'h7654_3210_DEAD_BEEF);
        run_vec("ld_zext_ignored", 1, 0, 64'hF654_3210_DEAD_BEEF, 0, 0, 3, 1, 2,
                64'hF654_3210_DEAD_BEEF);
        run_vec("imm", 2, 64'h1, 64'h2, 64'hFFFF_FFFF_FFFF_F000, 64'h3, 0, 0, 0,
                64'hFFFF_FFFF_FFFF_F000);
        run_vec("pc_plus4", 3, 64'h1, 64'h2, 64'h3, 64'h8000_0000, 0, 0, 0,
                64'h8000_0004);
        run_vec("pc_wrap", 3, 64'h1, 64'h2, 64'h3, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0,
                64'h0);

        for (int n = 0; n < 300; n++) begin
            r_alu  = {$urandom, $urandom};
            r_row  = {$urandom, $urandom};
            r_imm  = {$urandom, $urandom};
            r_pc   = {$urandom, $urandom};
            r_src  = int'($urandom_range(3, 0));
            r_size = int'($urandom_range(3, 0));
            r_idx  = int'($urandom_range(7, 0));
            r_zext = 1'($urandom_range(1, 0));
            exp    = model_out(r_src, r_alu, r_row, r_imm, r_pc, r_size, r_zext, r_idx);
            apply_stimulus(r_src, r_alu, r_row, r_imm, r_pc, r_size, r_zext, r_idx);
            check_output($sformatf("rand%0d_src%0d_sz%0d_i%0d", n, r_src, r_size, r_idx),
                         rf_wr_data_o, exp);
        end

`ifdef WRITEBACK_OUT_REG_EN
        // Mid-run reset clears the register at the next edge.
        reset_i = 1'b1;
        apply_stimulus(2, 0, 0, 64'h1111_2222_3333_4444, 0, 0, 0, 0);
        check_output("midrun_reset", rf_wr_data_o, 64'h0);
        reset_i = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
